// File: rtl/up_down_counter.sv
// Loadable WIDTH-bit up/down counter with asynchronous active-low clear.
// tc flags the wrap point in the current direction for cascading.
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             sel,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load is tested first so an unknown sel cannot reach the state while loading.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (sel) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = sel ? (&count_q) : ~(|count_q);

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter with hand-computed expectations.
module tb_up_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             load;
  logic             sel;
  logic [WIDTH-1:0] count;
  logic             tc;

  int errors = 0;
  int checks = 0;

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .load  (load),
    .sel   (sel),
    .count (count),
    .tc    (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    d    = '0;
    load = 1'b0;
    sel  = 1'b1;

    // Reset state
    #2;
    check("reset_count", 32'(count), 0);
    check("reset_tc_up", 32'(tc), 0);
    rst = 1'b1;

    // Count up to 7, then pulse reset between edges
    for (int i = 1; i <= 7; i++) tick();
    check("count_to_7", 32'(count), 7);
    #3 rst = 1'b0;
    #1 check("async_clear", 32'(count), 0);
    #1 rst = 1'b1;
    tick();
    check("post_reset_1", 32'(count), 1);
    tick();
    check("post_reset_2", 32'(count), 2);

    // Held load keeps count at d, sel ignored
    load = 1'b1; sel = 1'b1; d = 4'd13;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hold_load_13", 32'(count), 13);
    end
    check("tc_13_up", 32'(tc), 0);

    // Count down from 13
    load = 1'b0; sel = 1'b0;
    tick(); check("down_12", 32'(count), 12);
    tick(); check("down_11", 32'(count), 11);
    tick(); check("down_10", 32'(count), 10);

    // Up wrap
    load = 1'b1; d = 4'd14;
    tick(); check("load_14", 32'(count), 14);
    load = 1'b0; sel = 1'b1;
    tick(); check("up_15", 32'(count), 15); check("tc_up_15", 32'(tc), 1);
    tick(); check("up_wrap_0", 32'(count), 0); check("tc_up_0", 32'(tc), 0);
    tick(); check("up_1", 32'(count), 1);

    // Down wrap
    load = 1'b1; d = 4'd1;
    tick(); check("load_1", 32'(count), 1);
    load = 1'b0; sel = 1'b0;
    tick(); check("down_0", 32'(count), 0); check("tc_down_0", 32'(tc), 1);
    tick(); check("down_wrap_15", 32'(count), 15); check("tc_down_15", 32'(tc), 0);
    tick(); check("down_14", 32'(count), 14);

    // Load priority and direction change
    load = 1'b1; d = 4'd4;
    tick(); check("load_4", 32'(count), 4);
    load = 1'b0; sel = 1'b1;
    tick(); check("up_5", 32'(count), 5);
    load = 1'b1; d = 4'd9; sel = 1'b0;
    tick(); check("load_over_count_9", 32'(count), 9);
    load = 1'b0;
    tick(); check("dn_8", 32'(count), 8);
    tick(); check("dn_7", 32'(count), 7);
    sel = 1'b1;
    tick(); check("up_8", 32'(count), 8);
    tick(); check("up_9", 32'(count), 9);

    // tc depends on sel combinationally
    load = 1'b1; d = 4'd15;
    tick(); check("held_15", 32'(count), 15);
    #1 check("tc_15_sel1", 32'(tc), 1);
    sel = 1'b0;
    #1 check("tc_15_sel0", 32'(tc), 0);
    tick(); check("held_15_sel0", 32'(count), 15);
    d = 4'd0;
    tick(); check("held_0", 32'(count), 0);
    #1 check("tc_0_sel0", 32'(tc), 1);
    sel = 1'b1;
    #1 check("tc_0_sel1", 32'(tc), 0);

    // Unknown sel during load must not corrupt count
    sel = 1'bx; d = 4'd6;
    tick(); check("load_sel_x", 32'(count), 6);

    // Reset during a pending load discards it; unknown sel during reset is harmless
    d = 4'd3; sel = 1'b1;
    #3 rst = 1'b0;
    #1 check("clear_during_load", 32'(count), 0);
    sel = 1'bx;
    tick(); check("held_in_reset", 32'(count), 0);
    #2 rst = 1'b1; load = 1'b0; sel = 1'b1;
    tick(); check("release_up_1", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
# up_down_counter

Synchronous, loadable, 4-bit (parameterisable) up/down counter with asynchronous active-low reset. A direction select chooses increment or decrement each clock, and a parallel load overrides counting. A combinational terminal-count flag marks the wrap point for cascading or event generation. It is a general-purpose timing and sequence primitive within a single clock domain.

## Interface
Parameters:
- WIDTH, default 4, counter and load-data width in bits.

Ports, in positional order:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
  - rst=0 forces count to 0 immediately.
  - Release is synchronous to clk.
- d  input  WIDTH  parallel load value.
- load  input  1  synchronous load enable, active-high.
- sel  input  1  direction: 1 = count up, 0 = count down.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal count, combinational from count and sel.

The first six ports are in the order clk, rst, d, load, sel, count. tc is last, so a six-connection positional instantiation is legal.

## Operation
- Priority, highest first: reset, load, count.
- rst=0: count = 0, asynchronously, regardless of clk, load or sel.
- rst=1 and load=1 at a rising edge: count <= d. sel is ignored.
- rst=1, load=0, sel=1: count <= count + 1, modulo 2^WIDTH.
- rst=1, load=0, sel=0: count <= count - 1, modulo 2^WIDTH.
- No hold mode. With load=0 the counter moves every clock.
- Wrap-around:
  - up from 2^WIDTH-1 goes to 0;
  - down from 0 goes to 2^WIDTH-1.
  - There is no saturation and no error flag.
- tc:
  - 1 when sel=1 and count = 2^WIDTH-1;
  - 1 when sel=0 and count = 0;
  - otherwise 0.
  - tc is a pure function of current count and sel; it is not gated by load.
- Holding load high reloads d every cycle, so count stays at d.
- X on sel while load=1 or rst=0 must not corrupt count.

## Timing
- Load latency: count reflects d after the first rising edge at which load=1.
- Count latency: one clock per step. count updates only on rising clk edges, except for reset.
- Reset assertion: count = 0 within the same delta or time step as rst falling, with no clock needed.
- Reset deassertion: the first count or load occurs at the first rising edge after rst=1.
  - Example: deassert, then the next edge with sel=1 gives count = 1.
- Reset mid-operation (load or counting): count is cleared immediately. Pending load data is discarded.
- Changing sel or load between edges affects only the next edge.
- tc follows sel combinationally with no register delay.

## Test plan
- Reset:
  - Start counting with rst=1 and let count reach a nonzero value, e.g. 7.
  - Pulse rst=0 between clock edges.
  - Required: count = 0 immediately. After release with sel=1, count reads 1, then 2, on successive edges.
- Load then count down:
  - load=1, sel=1, d=13 for 6 cycles. Required: count = 13 every cycle.
  - Then load=0, sel=0. Required: count = 12, 11, 10, … on successive edges.
- Up wrap:
  - Load 14, then sel=1, load=0. Required: count = 15 (tc=1), then 0 (tc=0), then 1.
- Down wrap:
  - Load 1, then sel=0, load=0. Required: count = 0 (tc=1), then 15, then 14.
- Load priority and direction change:
  - While counting up at count = 5, assert load=1 with d=9 and sel=0 for one edge. Required: count = 9.
  - Release load. Required: count = 8, 7.
  - Flip sel to 1. Required: count = 8, 9.
- tc direction dependence:
  - With count held at 15 via load=1, d=15: tc=1 when sel=1 and tc=0 when sel=0.
  - With count held at 0: the reverse.
